// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_t : FSM encoding (BOOT, FETCH, HOLD, DISCARD), 2 bits
//   - NOP_INSTR     : default instruction word used for IF/ID bubbles
//   - pc_sel_t      : next-PC source select (SEQ, BR, JR, J)
//   - word_align    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEQ = 2'd0,
      BR  = 2'd1,
      JR  = 2'd2,
      J   = 2'd3
   } pc_sel_t;

   // Instructions are word aligned, so any redirect target has its two
   // low bits forced to zero rather than trusted from the source.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory.
//   Imem_Req   : fetch request (fetch stage -> memory)
//   Imem_Addr  : fetch address, stable while Imem_Req=1
//   Imem_Rdata : instruction word, meaningful when Imem_Valid=1
//   Imem_Valid : response strobe, may coincide with the request cycle
// Modports: master = fetch stage side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_stage_if;

   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic [31:0] Imem_Rdata;
   logic        Imem_Valid;

   modport master (
      output Imem_Req,
      output Imem_Addr,
      input  Imem_Rdata,
      input  Imem_Valid
   );

   modport slave (
      input  Imem_Req,
      input  Imem_Addr,
      output Imem_Rdata,
      output Imem_Valid
   );

endinterface

// File: rtl/next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Combinational next-PC selection with redirect priority
// Branch_Taken > Jump_Reg > Jump > sequential.
//   pc             : current fetch PC
//   pcplus4_region : IF/ID PC+4 bits [31:28], the region for J targets
//   branch_taken / branch_target   : resolved taken branch
//   jump_reg / jump_reg_addr       : JR with rs value
//   jump / jump_target             : J/JAL with instr[25:0]
//   next_pc  : selected next PC (word aligned when redirecting)
//   redirect : any redirect source is active
// ---------------------------------------------------------------------------
module next_pc_mux
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [3:0]  pcplus4_region,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] next_pc,
   output logic        redirect
);

   pc_sel_t sel;

   // Priority encode the redirect sources into a single select code.
   always_comb begin
      sel = SEQ;
      if (branch_taken) begin
         sel = BR;
      end else if (jump_reg) begin
         sel = JR;
      end else if (jump) begin
         sel = J;
      end
   end

   // Steer the chosen target; the sequential path wraps naturally at 2^32.
   always_comb begin
      next_pc = pc + 32'd4;
      case (sel)
         BR:      next_pc = word_align(branch_target);
         JR:      next_pc = word_align(jump_reg_addr);
         J:       next_pc = {pcplus4_region, jump_target, 2'b00};
         default: next_pc = pc + 32'd4;
      endcase
   end

   assign redirect = (sel != SEQ);

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, fetches
// over the imem handshake, applies branch/JR/J redirects, absorbs ID stalls
// through a one-word skid buffer, and throws away responses that belong to a
// request issued before a redirect.
//   Clk, Rst           : rising-edge clock, asynchronous active-low reset
//   Stall              : hold PC and IF/ID
//   Flush              : bubble IF/ID on the next edge
//   Branch_Taken/Target, Jump_Reg/Jump_Reg_Addr, Jump/Jump_Target : redirects
//   imem               : instruction-memory master port
//   IFID_Instruction, IFID_PCPlus4, IFID_Valid : IF/ID register to decode
//   PC                 : current fetch PC
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Stall,
   input  logic          Flush,
   input  logic          Branch_Taken,
   input  logic [31:0]   Branch_Target,
   input  logic          Jump,
   input  logic [25:0]   Jump_Target,
   input  logic          Jump_Reg,
   input  logic [31:0]   Jump_Reg_Addr,
   fetch_stage_if.master imem,
   output logic [31:0]   IFID_Instruction,
   output logic [31:0]   IFID_PCPlus4,
   output logic          IFID_Valid,
   output logic [31:0]   PC
);

   import fetch_pkg::*;

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  skid_q, skid_d;
   logic [31:0]  stale_addr_q, stale_addr_d;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic [31:0]  ifid_pcplus4_q, ifid_pcplus4_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [31:0]  next_pc;
   logic         redirect;
   logic [31:0]  pc_plus4;
   logic         hold_fetch;

   next_pc_mux u_next_pc_mux (
      .pc             (pc_q),
      .pcplus4_region (ifid_pcplus4_q[31:28]),
      .branch_taken   (Branch_Taken),
      .branch_target  (Branch_Target),
      .jump_reg       (Jump_Reg),
      .jump_reg_addr  (Jump_Reg_Addr),
      .jump           (Jump),
      .jump_target    (Jump_Target),
      .next_pc        (next_pc),
      .redirect       (redirect)
   );

   assign pc_plus4 = pc_q + 32'd4;

   // A flush bubbles IF/ID regardless of Stall, so from the fetch side the
   // word counts as consumed; only a stall without flush really holds.
   assign hold_fetch = Stall & ~Flush;

   // State, PC, skid buffer and IF/ID register. Reset leaves IF/ID holding a
   // bubble and the FSM in BOOT so the first request goes out one cycle later.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q        <= BOOT;
         pc_q           <= RESET_PC;
         skid_q         <= 32'h0000_0000;
         stale_addr_q   <= RESET_PC;
         ifid_instr_q   <= NOP_INSTR;
         ifid_pcplus4_q <= 32'h0000_0000;
         ifid_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         skid_q         <= skid_d;
         stale_addr_q   <= stale_addr_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pcplus4_q <= ifid_pcplus4_d;
         ifid_valid_q   <= ifid_valid_d;
      end
   end

   // Next-state and datapath control. A redirect always wins over Stall.
   // When a redirect arrives with the request still outstanding we move to
   // DISCARD, keep presenting the old address until memory answers, and drop
   // that answer; the new PC is then fetched from FETCH. A final override
   // turns any redirect or flush into an IF/ID bubble.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      skid_d         = skid_q;
      stale_addr_d   = stale_addr_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;
      imem.Imem_Req  = 1'b0;
      imem.Imem_Addr = pc_q;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
            if (redirect) begin
               pc_d = next_pc;
            end
         end

         FETCH: begin
            imem.Imem_Req = 1'b1;
            if (redirect) begin
               pc_d = next_pc;
               if (!imem.Imem_Valid) begin
                  state_d      = DISCARD;
                  stale_addr_d = pc_q;
               end
            end else if (imem.Imem_Valid) begin
               if (!hold_fetch) begin
                  ifid_instr_d   = imem.Imem_Rdata;
                  ifid_pcplus4_d = pc_plus4;
                  ifid_valid_d   = 1'b1;
                  pc_d           = pc_plus4;
               end else begin
                  skid_d  = imem.Imem_Rdata;
                  state_d = HOLD;
               end
            end else if (!Stall) begin
               ifid_instr_d   = NOP_INSTR;
               ifid_pcplus4_d = 32'h0000_0000;
               ifid_valid_d   = 1'b0;
            end
         end

         HOLD: begin
            if (redirect) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end else if (!hold_fetch) begin
               ifid_instr_d   = skid_q;
               ifid_pcplus4_d = pc_plus4;
               ifid_valid_d   = 1'b1;
               pc_d           = pc_plus4;
               state_d        = FETCH;
            end
         end

         DISCARD: begin
            imem.Imem_Req  = 1'b1;
            imem.Imem_Addr = stale_addr_q;
            if (redirect) begin
               pc_d = next_pc;
            end
            if (imem.Imem_Valid) begin
               state_d = FETCH;
            end
            if (!Stall) begin
               ifid_instr_d   = NOP_INSTR;
               ifid_pcplus4_d = 32'h0000_0000;
               ifid_valid_d   = 1'b0;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      if (redirect || Flush) begin
         ifid_instr_d   = NOP_INSTR;
         ifid_pcplus4_d = 32'h0000_0000;
         ifid_valid_d   = 1'b0;
      end
   end

   assign IFID_Instruction = ifid_instr_q;
   assign IFID_PCPlus4     = ifid_pcplus4_q;
   assign IFID_Valid       = ifid_valid_q;
   assign PC               = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A behavioural instruction memory answers
// each request with Addr|32'hA000_0000 after a programmable number of wait
// cycles. Expected IF/ID contents are queued by the stimulus thread and a
// separate monitor pops and compares each newly loaded instruction.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall;
   logic        Flush;
   logic        Branch_Taken;
   logic [31:0] Branch_Target;
   logic        Jump;
   logic [25:0] Jump_Target;
   logic        Jump_Reg;
   logic [31:0] Jump_Reg_Addr;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic [31:0] PC;

   int compared   = 0;
   int mismatched = 0;

   int unsigned mem_lat  = 0;
   int unsigned wait_cnt = 0;
   logic        stall_seen = 1'b0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } exp_t;

   exp_t exp_q[$];

   fetch_stage_if imem();

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .Clk              (Clk),
      .Rst              (Rst),
      .Stall            (Stall),
      .Flush            (Flush),
      .Branch_Taken     (Branch_Taken),
      .Branch_Target    (Branch_Target),
      .Jump             (Jump),
      .Jump_Target      (Jump_Target),
      .Jump_Reg         (Jump_Reg),
      .Jump_Reg_Addr    (Jump_Reg_Addr),
      .imem             (imem),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PCPlus4     (IFID_PCPlus4),
      .IFID_Valid       (IFID_Valid),
      .PC               (PC)
   );

   // Free-running 10-unit clock.
   always #5 Clk = ~Clk;

   // Behavioural memory: valid once the request has waited mem_lat cycles,
   // so mem_lat=0 gives a zero-wait response in the request cycle.
   assign imem.Imem_Valid = imem.Imem_Req && (wait_cnt >= mem_lat);
   assign imem.Imem_Rdata = imem.Imem_Valid ? (imem.Imem_Addr | 32'hA000_0000) : 32'hDEAD_BEEF;

   // Wait-cycle counter restarts whenever a response completes or no
   // request is outstanding.
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wait_cnt <= 0;
      end else if (!imem.Imem_Req || imem.Imem_Valid) begin
         wait_cnt <= 0;
      end else begin
         wait_cnt <= wait_cnt + 1;
      end
   end

   // Remember whether the last edge was stalled: a valid IF/ID seen after a
   // non-stalled edge is a freshly loaded instruction.
   always @(posedge Clk) begin
      stall_seen <= Stall;
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic [31:0] pcplus4);
      exp_t e;
      e.instr   = instr;
      e.pcplus4 = pcplus4;
      exp_q.push_back(e);
   endtask

   task automatic apply_stimulus(input logic st, input logic fl,
                                 input logic bt, input logic [31:0] btgt,
                                 input logic jr, input logic [31:0] jra,
                                 input logic j,  input logic [25:0] jt);
      Stall         = st;
      Flush         = fl;
      Branch_Taken  = bt;
      Branch_Target = btgt;
      Jump_Reg      = jr;
      Jump_Reg_Addr = jra;
      Jump          = j;
      Jump_Target   = jt;
   endtask

   task automatic step();
      @(negedge Clk);
   endtask

   // Monitor: every newly loaded IF/ID instruction must match the head of
   // the expectation queue, in order.
   always @(negedge Clk) begin
      exp_t e;
      if (Rst === 1'b1 && IFID_Valid === 1'b1 && !stall_seen) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_ifid: got %h/%h, expected none", IFID_Instruction, IFID_PCPlus4);
         end else begin
            e = exp_q.pop_front();
            check_output("ifid_instr", IFID_Instruction, e.instr);
            check_output("ifid_pcplus4", IFID_PCPlus4, e.pcplus4);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      Rst = 1'b0;
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      step();
      step();

      check_output("rst_pc", PC, 32'h0);
      check_output("rst_addr", imem.Imem_Addr, 32'h0);
      check_output("rst_req", {31'h0, imem.Imem_Req}, 32'h0);
      check_output("rst_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      check_output("rst_ifid_instr", IFID_Instruction, 32'h0);
      check_output("rst_ifid_pcplus4", IFID_PCPlus4, 32'h0);

      // Zero-wait streaming.
      Rst = 1'b1;
      push_exp(32'hA000_0000, 32'h4);
      push_exp(32'hA000_0004, 32'h8);
      push_exp(32'hA000_0008, 32'hC);
      push_exp(32'hA000_000C, 32'h10);
      step();
      check_output("boot_pc", PC, 32'h0);
      check_output("boot_req", {31'h0, imem.Imem_Req}, 32'h1);
      check_output("boot_addr", imem.Imem_Addr, 32'h0);
      check_output("boot_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      step();
      check_output("seq_pc4", PC, 32'h4);
      step();
      check_output("seq_pc8", PC, 32'h8);
      step();
      check_output("seq_pc12", PC, 32'hC);

      // Two wait cycles per fetch: address held, bubbles inserted.
      mem_lat = 2;
      push_exp(32'hA000_0010, 32'h14);
      for (int k = 0; k < 2; k++) begin
         step();
         check_output("wait_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
         check_output("wait_ifid_instr", IFID_Instruction, 32'h0);
         check_output("wait_addr_a", imem.Imem_Addr, 32'hC + 32'(4 * k));
         step();
         check_output("wait_addr_b", imem.Imem_Addr, 32'hC + 32'(4 * k));
         step();
         check_output("wait_pc", PC, 32'h10 + 32'(4 * k));
      end

      // Stall on a valid cycle: word parked in the skid buffer.
      mem_lat = 0;
      push_exp(32'hA000_0014, 32'h18);
      push_exp(32'hA000_0018, 32'h1C);
      Stall = 1'b1;
      step();
      check_output("hold_req", {31'h0, imem.Imem_Req}, 32'h0);
      check_output("hold_pc", PC, 32'h14);
      check_output("hold_ifid_instr", IFID_Instruction, 32'hA000_0010);
      check_output("hold_ifid_pcplus4", IFID_PCPlus4, 32'h14);
      step();
      check_output("hold_req2", {31'h0, imem.Imem_Req}, 32'h0);
      step();
      check_output("hold_req3", {31'h0, imem.Imem_Req}, 32'h0);
      check_output("hold_ifid_pcplus4_3", IFID_PCPlus4, 32'h14);
      Stall = 1'b0;
      step();
      check_output("release_pc", PC, 32'h18);
      check_output("release_addr", imem.Imem_Addr, 32'h18);
      step();
      check_output("release_pc2", PC, 32'h1C);

      // Branch into region 1, then J with Flush using IFID_PCPlus4 region.
      push_exp(32'hB000_0004, 32'h1000_0008);
      apply_stimulus(0, 0, 1, 32'h1000_0004, 0, 32'h0, 0, 26'h0);
      step();
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      check_output("br_pc", PC, 32'h1000_0004);
      check_output("br_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      step();
      check_output("br_pc2", PC, 32'h1000_0008);
      push_exp(32'hB000_0100, 32'h1000_0104);
      apply_stimulus(0, 1, 0, 32'h0, 0, 32'h0, 1, 26'h000_0040);
      step();
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      check_output("j_pc", PC, 32'h1000_0100);
      check_output("j_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      check_output("j_ifid_instr", IFID_Instruction, 32'h0);
      step();
      check_output("j_pc2", PC, 32'h1000_0104);

      // Branch while a 3-wait fetch is pending: stale word discarded.
      mem_lat = 3;
      apply_stimulus(0, 0, 1, 32'h0000_0203, 0, 32'h0, 0, 26'h0);
      step();
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      check_output("disc_addr", imem.Imem_Addr, 32'h1000_0104);
      check_output("disc_req", {31'h0, imem.Imem_Req}, 32'h1);
      check_output("disc_pc", PC, 32'h200);
      check_output("disc_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      step();
      check_output("disc_addr2", imem.Imem_Addr, 32'h1000_0104);
      step();
      check_output("disc_addr3", imem.Imem_Addr, 32'h1000_0104);
      step();
      check_output("refetch_addr", imem.Imem_Addr, 32'h200);
      check_output("refetch_req", {31'h0, imem.Imem_Req}, 32'h1);
      check_output("refetch_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      mem_lat = 0;
      push_exp(32'hA000_0200, 32'h204);
      step();
      check_output("refetch_pc", PC, 32'h204);

      // Branch and JR together under Stall: branch wins, Stall ignored.
      apply_stimulus(1, 0, 1, 32'h0000_0300, 1, 32'h80, 0, 26'h0);
      step();
      check_output("prio_pc", PC, 32'h300);
      check_output("prio_ifid_valid", {31'h0, IFID_Valid}, 32'h0);
      // JR beats J; low bits of the rs value are cleared.
      apply_stimulus(0, 0, 0, 32'h0, 1, 32'h83, 1, 26'h3FF_FFFF);
      step();
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      check_output("jr_pc", PC, 32'h80);
      push_exp(32'hA000_0080, 32'h84);
      step();
      check_output("jr_pc2", PC, 32'h84);

      // PC+4 wrap at the top of the address space.
      push_exp(32'hFFFF_FFFC, 32'h0);
      push_exp(32'hA000_0000, 32'h4);
      apply_stimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 26'h0);
      step();
      apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 0, 26'h0);
      check_output("wrap_pc_top", PC, 32'hFFFF_FFFC);
      step();
      check_output("wrap_pc_zero", PC, 32'h0);
      check_output("wrap_addr", imem.Imem_Addr, 32'h0);
      step();
      check_output("wrap_pc4", PC, 32'h4);

      // Freeze the pipe and confirm every expected instruction arrived.
      Stall = 1'b1;
      step();
      step();
      check_output("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
